// File: rtl/vga_pkg.sv
// Shared types and sizing for the blink-RAM controller.
// Pure declarations: no latency, no flow control.
package vga_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT1 = 3'd1,
        RD_WAIT2 = 3'd2,
        ACK      = 3'd3,
        FILL     = 3'd4
    } state_t;

    localparam int BLINKRAM_DEPTH  = 300;
    localparam int BLINKRAM_ADDR_W = 9;

endpackage

// File: rtl/blink_ram_ctrl_if.sv
// CPU access bus of the blink-RAM controller (req/ack handshake, byte wide).
// No latency of its own; the requester holds req high until ack.
interface blink_ram_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic              ack;
    logic [7:0]        rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/blink_timer.sv
// Free-running blink divider: phase toggles every BLINK_DIV cycles, starts at 1.
// No handshake; runs every cycle.
module blink_timer #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    output logic phase
);
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          wrap;

    assign wrap = (cnt_q == CW'(BLINK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            phase <= 1'b1;
        end else if (wrap) begin
            cnt_q <= '0;
            phase <= ~phase;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/blink_ram_ctrl.sv
// Arbitrates CPU byte access and whole-RAM fill onto the blink-RAM port; write ack 1 cycle, read ack 3 cycles after accept.
// CPU stalls (no ack) while a fill is pending or running; blink timer only built with BLINK_RAM_CTRL_TIMER_EN.
module blink_ram_ctrl
    import vga_pkg::*;
#(
    parameter int DEPTH     = BLINKRAM_DEPTH,
    parameter int ADDR_W    = BLINKRAM_ADDR_W,
    parameter int BLINK_DIV = 25000000
) (
    input  logic              sysclk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]        cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [7:0]        cpu_rdata_o,
    input  logic              fill_start_i,
    input  logic [7:0]        fill_value_i,
    output logic              fill_busy_o,
    output logic              fill_done_o,
    output logic [ADDR_W-1:0] blinkram_addr_o,
    output logic [7:0]        blinkram_data_o,
    output logic              blinkram_wren_o,
    input  logic [7:0]        blinkram_data_i,
    output logic              blink_phase_o
);
    state_t            state_q, state_d;
    logic              pending_q;
    logic [7:0]        fill_val_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic              rd_oob_q;
    logic [7:0]        rdata_q;
    logic              done_q;

    logic fill_accept, fill_now, fill_last, cpu_oob, rd_accept;

    // A start arriving in IDLE goes straight to FILL so it wins over a same-cycle CPU request.
    assign fill_accept = fill_start_i && !pending_q && (state_q != FILL);
    assign fill_now    = pending_q || fill_accept;
    assign fill_last   = (fill_addr_q == ADDR_W'(DEPTH - 1));
    assign cpu_oob     = (int'(cpu_addr_i) >= DEPTH);
    assign rd_accept   = (state_q == IDLE) && !fill_now && cpu_req_i && !cpu_we_i;

    always_comb begin
        state_d         = state_q;
        blinkram_addr_o = '0;
        blinkram_data_o = '0;
        blinkram_wren_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill_now) begin
                    state_d = FILL;
                end else if (cpu_req_i) begin
                    blinkram_addr_o = cpu_addr_i;
                    if (cpu_we_i) begin
                        blinkram_data_o = cpu_wdata_i;
                        blinkram_wren_o = !cpu_oob;
                        state_d         = ACK;
                    end else begin
                        state_d = RD_WAIT1;
                    end
                end
            end
            RD_WAIT1: state_d = RD_WAIT2;
            RD_WAIT2: state_d = ACK;
            ACK:      state_d = IDLE;
            FILL: begin
                blinkram_addr_o = fill_addr_q;
                blinkram_data_o = fill_val_q;
                blinkram_wren_o = 1'b1;
                if (fill_last) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            fill_val_q  <= '0;
            fill_addr_q <= '0;
            rd_oob_q    <= 1'b0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fill_accept) fill_val_q <= fill_value_i;
            if ((state_q == IDLE) && fill_now) pending_q <= 1'b0;
            else if (fill_accept)              pending_q <= 1'b1;
            if (state_q == FILL) fill_addr_q <= fill_last ? '0 : fill_addr_q + 1'b1;
            done_q <= (state_q == FILL) && fill_last;
            if (rd_accept) rd_oob_q <= cpu_oob;
            // RAM returns data two cycles after the address, i.e. during RD_WAIT2.
            if (state_q == RD_WAIT2) rdata_q <= rd_oob_q ? 8'h00 : blinkram_data_i;
        end
    end

    assign cpu_ack_o   = (state_q == ACK);
    assign cpu_rdata_o = rdata_q;
    assign fill_busy_o = pending_q || (state_q == FILL);
    assign fill_done_o = done_q;

`ifdef BLINK_RAM_CTRL_TIMER_EN
    blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_timer (
        .clk   (sysclk_i),
        .rst   (rst_i),
        .phase (blink_phase_o)
    );
`else
    assign blink_phase_o = 1'b1;
`endif
endmodule

// File: tb/tb_blink_ram_ctrl.sv
// Bench for blink_ram_ctrl: vector table, random traffic against a memory model, fill/reset/blink sequences.
`timescale 1ns/1ps
module tb_blink_ram_ctrl;
    localparam int DEPTH  = 300;
    localparam int ADDR_W = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    blink_ram_ctrl_if #(.ADDR_W(ADDR_W)) cpu_bus ();

    logic              fill_start, fill_busy, fill_done, wren, phase;
    logic [7:0]        fill_value, ram_dout, ram_din;
    logic [ADDR_W-1:0] ram_addr;

    blink_ram_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BLINK_DIV(4)
    ) dut (
        .sysclk_i        (clk),
        .rst_i           (rst),
        .cpu_req_i       (cpu_bus.req),
        .cpu_we_i        (cpu_bus.we),
        .cpu_addr_i      (cpu_bus.addr),
        .cpu_wdata_i     (cpu_bus.wdata),
        .cpu_ack_o       (cpu_bus.ack),
        .cpu_rdata_o     (cpu_bus.rdata),
        .fill_start_i    (fill_start),
        .fill_value_i    (fill_value),
        .fill_busy_o     (fill_busy),
        .fill_done_o     (fill_done),
        .blinkram_addr_o (ram_addr),
        .blinkram_data_o (ram_dout),
        .blinkram_wren_o (wren),
        .blinkram_data_i (ram_din),
        .blink_phase_o   (phase)
    );

    // Blink-RAM with two-cycle read latency.
    logic [7:0] ram [0:511];
    logic [7:0] rd1, rd2;
    always @(posedge clk) begin
        if (wren) ram[ram_addr] <= ram_dout;
        rd1 <= ram[ram_addr];
        rd2 <= rd1;
    end
    assign ram_din = rd2;

    logic [7:0] ref_mem [0:DEPTH-1];
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       we;
        int         addr;
        logic [7:0] wdata;
        int         exp_lat;
        int         exp_wr;
        logic [7:0] exp_rd;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the ack cycle.
    task automatic cpu_access(input logic we, input int a, input logic [7:0] d,
                              output int lat, output int rd, output int wr_cnt,
                              output int wr_addr, output int wr_dat);
        cpu_bus.req = 1'b1; cpu_bus.we = we; cpu_bus.addr = ADDR_W'(a); cpu_bus.wdata = d;
        lat = -1; rd = -1; wr_cnt = 0; wr_addr = -1; wr_dat = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (wren) begin wr_cnt++; wr_addr = int'(ram_addr); wr_dat = int'(ram_dout); end
            if (cpu_bus.ack) begin lat = c; rd = int'(cpu_bus.rdata); break; end
        end
        @(posedge clk); #1;
        cpu_bus.req = 1'b0; cpu_bus.we = 1'b0;
    endtask

    function automatic int exp_read(input int a);
        return (a < DEPTH) ? int'(ref_mem[a]) : 0;
    endfunction

    vec_t vecs [0:10];

    initial begin
        int lat, rd, wc, wa, wd;
        int wr_cnt, addr_err, data_err, busy_err, done_cnt, done_cycle, busy_at_done, ack_cycle;
        int found, toggles, ivl_err, last_t, ones_err;
        logic prev;

        for (int i = 0; i < 512; i++) ram[i] = 8'h00;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        rd1 = 8'h00; rd2 = 8'h00;

        vecs[0]  = '{1'b1,   5, 8'hA5, 1, 1, 8'h00};
        vecs[1]  = '{1'b0,   5, 8'h00, 3, 0, 8'hA5};
        vecs[2]  = '{1'b1, 299, 8'h3C, 1, 1, 8'h00};
        vecs[3]  = '{1'b0, 299, 8'h00, 3, 0, 8'h3C};
        vecs[4]  = '{1'b1, 300, 8'h77, 1, 0, 8'h00};
        vecs[5]  = '{1'b0, 300, 8'h00, 3, 0, 8'h00};
        vecs[6]  = '{1'b1,   0, 8'hE1, 1, 1, 8'h00};
        vecs[7]  = '{1'b0,   0, 8'h00, 3, 0, 8'hE1};
        vecs[8]  = '{1'b1, 511, 8'h99, 1, 0, 8'h00};
        vecs[9]  = '{1'b0, 511, 8'h00, 3, 0, 8'h00};
        vecs[10] = '{1'b0,   6, 8'h00, 3, 0, 8'h00};

        rst = 1'b1;
        cpu_bus.req = 1'b0; cpu_bus.we = 1'b0; cpu_bus.addr = '0; cpu_bus.wdata = '0;
        fill_start = 1'b0; fill_value = '0;
        #12;
        check("reset_ack",   int'(cpu_bus.ack),   0);
        check("reset_rdata", int'(cpu_bus.rdata), 0);
        check("reset_busy",  int'(fill_busy),     0);
        check("reset_done",  int'(fill_done),     0);
        check("reset_wren",  int'(wren),          0);
        check("reset_addr",  int'(ram_addr),      0);
        check("reset_data",  int'(ram_dout),      0);
        check("reset_phase", int'(phase),         1);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            cpu_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, wc, wa, wd);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_wr", i), wc, vecs[i].exp_wr);
            if (vecs[i].exp_wr != 0) begin
                check($sformatf("vec%0d_waddr", i), wa, vecs[i].addr);
                check($sformatf("vec%0d_wdata", i), wd, int'(vecs[i].wdata));
                ref_mem[vecs[i].addr] = vecs[i].wdata;
            end
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, int'(vecs[i].exp_rd));
        end

        // Whole-RAM fill with a second start mid-fill that must be ignored.
        wr_cnt = 0; addr_err = 0; data_err = 0; busy_err = 0; done_cnt = 0;
        done_cycle = -1; busy_at_done = -1;
        for (int c = 0; c < 310; c++) begin
            if (c == 0)       begin fill_start = 1'b1; fill_value = 8'hFF; end
            else if (c == 50) begin fill_start = 1'b1; fill_value = 8'h00; end
            else                    fill_start = 1'b0;
            @(negedge clk);
            if (wren) begin
                if (int'(ram_addr) != wr_cnt) addr_err++;
                if (ram_dout != 8'hFF) data_err++;
                if (!fill_busy) busy_err++;
                wr_cnt++;
            end
            if (fill_done) begin done_cnt++; done_cycle = c; busy_at_done = int'(fill_busy); end
            @(posedge clk); #1;
        end
        fill_start = 1'b0;
        check("fill_writes", wr_cnt, DEPTH);
        check("fill_addr_seq", addr_err, 0);
        check("fill_data", data_err, 0);
        check("fill_busy", busy_err, 0);
        check("fill_done_cnt", done_cnt, 1);
        check("fill_done_cycle", done_cycle, 301);
        check("fill_busy_at_done", busy_at_done, 0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hFF;

        // Same-cycle CPU write and fill start: fill first, then the write.
        cpu_bus.req = 1'b1; cpu_bus.we = 1'b1; cpu_bus.addr = 9'd7; cpu_bus.wdata = 8'h42;
        fill_start = 1'b1; fill_value = 8'h11;
        wr_cnt = 0; done_cycle = -1; ack_cycle = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (wren) wr_cnt++;
            if (fill_done) done_cycle = c;
            if (cpu_bus.ack) begin ack_cycle = c; break; end
            @(posedge clk); #1;
            fill_start = 1'b0;
        end
        @(posedge clk); #1;
        cpu_bus.req = 1'b0; cpu_bus.we = 1'b0; fill_start = 1'b0;
        check("prio_done_cycle", done_cycle, 301);
        check("prio_ack_cycle", ack_cycle, 302);
        check("prio_writes", wr_cnt, DEPTH + 1);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h11;
        ref_mem[7] = 8'h42;

        // Random traffic against the memory model.
        for (int n = 0; n < 60; n++) begin
            logic we_r;
            int a;
            logic [7:0] d;
            we_r = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH, 511)) : int'($urandom_range(0, 31));
            d = 8'($urandom);
            cpu_access(we_r, a, d, lat, rd, wc, wa, wd);
            check($sformatf("rnd%0d_lat", n), lat, we_r ? 1 : 3);
            check($sformatf("rnd%0d_wr", n), wc, (we_r && a < DEPTH) ? 1 : 0);
            if (we_r) begin
                if (a < DEPTH) ref_mem[a] = d;
            end else begin
                check($sformatf("rnd%0d_rdata", n), rd, exp_read(a));
            end
        end

        // Reset while the fill is writing address 100.
        found = 0;
        for (int c = 0; c < 400; c++) begin
            fill_start = (c == 0); fill_value = 8'h5A;
            @(negedge clk);
            if (wren && int'(ram_addr) == 100) begin
                rst = 1'b1; #1;
                found = 1;
                check("rst_mid_wren", int'(wren), 0);
                check("rst_mid_busy", int'(fill_busy), 0);
                check("rst_mid_done", int'(fill_done), 0);
                check("rst_mid_phase", int'(phase), 1);
                break;
            end
            @(posedge clk); #1;
        end
        fill_start = 1'b0;
        check("rst_mid_found", found, 1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        wr_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (wren || fill_busy) wr_cnt++;
        end
        @(posedge clk); #1;
        check("rst_pending_cleared", wr_cnt, 0);
        for (int i = 0; i < 100; i++) ref_mem[i] = 8'h5A;
        cpu_access(1'b0, 99, 8'h00, lat, rd, wc, wa, wd);
        check("post_rst_lat", lat, 3);
        check("post_rst_rd99", rd, exp_read(99));
        cpu_access(1'b0, 100, 8'h00, lat, rd, wc, wa, wd);
        check("post_rst_rd100", rd, exp_read(100));

        // Blink phase over 40 cycles.
        toggles = 0; ivl_err = 0; last_t = -1; ones_err = 0;
        @(negedge clk); prev = phase;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (phase !== 1'b1) ones_err++;
            if (phase != prev) begin
                if (last_t >= 0 && (c - last_t) != 4) ivl_err++;
                last_t = c;
                toggles++;
            end
            prev = phase;
        end
`ifdef BLINK_RAM_CTRL_TIMER_EN
        check("blink_toggles", toggles, 10);
        check("blink_interval", ivl_err, 0);
`else
        check("blink_const_one", ones_err, 0);
        check("blink_toggles", toggles, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
